// File: rtl/ps2_cmd_seq_if.sv
// Signal bundle between ps2_cmd_seq and its PS/2 tx/rx neighbours and host logic.
// cmd_valid/cmd_ready: a command transfers on the cycle both are 1; cmd_data is held while cmd_valid=1.
interface ps2_cmd_seq_if;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] tx_din;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_done_tick;
  logic       cmd_err;
  logic       strm_valid;
  logic [7:0] strm_data;
  logic       init_done;
  logic       init_fail;
  logic [2:0] state_dbg;

  modport master (
    input  tx_idle, tx_done_tick, rx_done_tick, rx_dout, cmd_valid, cmd_data,
    output wr_ps2, tx_din, cmd_ready, cmd_done_tick, cmd_err,
           strm_valid, strm_data, init_done, init_fail, state_dbg
  );

  modport slave (
    output tx_idle, tx_done_tick, rx_done_tick, rx_dout, cmd_valid, cmd_data,
    input  wr_ps2, tx_din, cmd_ready, cmd_done_tick, cmd_err,
           strm_valid, strm_data, init_done, init_fail, state_dbg
  );
endinterface

// File: rtl/ps2_cmd_seq.sv
// PS/2 command sequencer: sends the init byte, then user commands, pairing each
// transmitted byte with the device acknowledge and forwarding unsolicited bytes.
module ps2_cmd_seq #(
  parameter logic [7:0] INIT_CMD    = 8'hF4,
  parameter int         ACK_TIMEOUT = 2_000_000,
  parameter int         TMR_W       = 21,
  parameter int         MAX_RETRY   = 3
) (
  input logic         clk,
  input logic         reset,
  ps2_cmd_seq_if.master bus
);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_SEND   = 3'd1,
    S_TXW    = 3'd2,
    S_ACKW   = 3'd3,
    S_STREAM = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t             state;
  logic [7:0]         cur_byte;
  logic               is_init;
  logic [RTY_W-1:0]   retry_cnt;
  logic [TMR_W-1:0]   timer;

  logic rx_ack, rx_nak, tmo, accept;

  // A received byte always beats an expiring timer in the same cycle.
  assign rx_ack = bus.rx_done_tick && (bus.rx_dout == 8'hFA);
  assign rx_nak = bus.rx_done_tick && (bus.rx_dout == 8'hFE);
  assign tmo    = !bus.rx_done_tick && (timer == '0);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready = (state == S_STREAM) && bus.tx_idle;
  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_INIT;
      cur_byte          <= 8'h00;
      is_init           <= 1'b0;
      retry_cnt         <= '0;
      timer             <= '0;
      bus.wr_ps2        <= 1'b0;
      bus.tx_din        <= 8'h00;
      bus.cmd_done_tick <= 1'b0;
      bus.cmd_err       <= 1'b0;
      bus.strm_valid    <= 1'b0;
      bus.strm_data     <= 8'h00;
      bus.init_done     <= 1'b0;
      bus.init_fail     <= 1'b0;
    end else begin
      bus.wr_ps2        <= 1'b0;
      bus.cmd_done_tick <= 1'b0;
      bus.cmd_err       <= 1'b0;
      bus.strm_valid    <= 1'b0;
      case (state)
        S_INIT: begin
          cur_byte  <= INIT_CMD;
          is_init   <= 1'b1;
          retry_cnt <= '0;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (bus.tx_idle) begin
            bus.wr_ps2 <= 1'b1;
            bus.tx_din <= cur_byte;
            state      <= S_TXW;
          end
        end
        S_TXW: begin
          if (bus.tx_done_tick) begin
            timer <= TMR_W'(ACK_TIMEOUT);
            state <= S_ACKW;
          end
        end
        S_ACKW: begin
          if (rx_ack) begin
            if (is_init) bus.init_done <= 1'b1;
            else         bus.cmd_done_tick <= 1'b1;
            state <= S_STREAM;
          end else if (rx_nak || tmo) begin
            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_SEND;
            end else if (is_init) begin
              bus.init_fail <= 1'b1;
              state         <= S_FAIL;
            end else begin
              bus.cmd_done_tick <= 1'b1;
              bus.cmd_err       <= 1'b1;
              state             <= S_STREAM;
            end
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end
        S_STREAM: begin
          if (bus.rx_done_tick) begin
            bus.strm_valid <= 1'b1;
            bus.strm_data  <= bus.rx_dout;
          end
          if (accept) begin
            cur_byte  <= bus.cmd_data;
            is_init   <= 1'b0;
            retry_cnt <= '0;
            state     <= S_SEND;
          end
        end
        S_FAIL:  state <= S_FAIL;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Scoreboard bench for ps2_cmd_seq with behavioural PS/2 tx/rx models and a
// transaction-level reference model of the command/acknowledge protocol.
module tb_ps2_cmd_seq;
  localparam int ACK_TIMEOUT = 100;
  localparam int MAX_RETRY   = 3;
  localparam int TX_LAT      = 15;
  localparam logic [1:0] K_WR = 2'd1, K_STRM = 2'd2, K_DONE = 2'd3;
  localparam int R_FA = 0, R_FE = 1, R_TO = 2, R_FA0 = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ps2_cmd_seq_if bus();

  ps2_cmd_seq #(
    .INIT_CMD(8'hF4), .ACK_TIMEOUT(ACK_TIMEOUT), .TMR_W(21), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---- clock / reset / cycle count ----
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [9:0] exp_q[$];
  int wr_cnt = 0, done_cnt = 0;
  int last_wr_cyc = 0, done_cyc = 0, last_rx_cyc = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---- behavioural PS/2 transmitter ----
  initial begin
    bus.tx_idle = 1'b1;
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_ps2) begin
        tick();
        bus.tx_idle = 1'b0;
        repeat (TX_LAT) tick();
        bus.tx_done_tick = 1'b1;
        done_cyc = cyc;
        done_cnt++;
        tick();
        bus.tx_done_tick = 1'b0;
        bus.tx_idle = 1'b1;
      end
    end
  end

  // ---- monitor: pops the scoreboard whenever the DUT presents an output event ----
  task automatic sb_pop(input logic [9:0] act, input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: actual=%0h required=no event expected (t=%0t)", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(act == e, name, 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_ps2) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      sb_pop({K_WR, bus.tx_din}, "wr_ps2");
    end
    if (bus.strm_valid) begin
      sb_pop({K_STRM, bus.strm_data}, "strm");
      check(cyc == last_rx_cyc + 1, "strm_latency", 32'(cyc - last_rx_cyc), 32'd1);
    end
    if (bus.cmd_done_tick)
      sb_pop({K_DONE, 7'd0, bus.cmd_err}, "cmd_done");
  end

  // ---- driver tasks ----
  task automatic send_rx(input logic [7:0] b);
    bus.rx_dout = b;
    bus.rx_done_tick = 1'b1;
    last_rx_cyc = cyc;
    tick();
    bus.rx_done_tick = 1'b0;
  endtask

  function automatic logic [7:0] garbage();
    logic [7:0] g = 8'($urandom);
    if (g == 8'hFA || g == 8'hFE) g = 8'h55;
    return g;
  endfunction

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 1000) begin tick(); t++; end
    check(done_cnt >= n, "wait_tx_done", 32'(done_cnt), 32'(n));
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_cnt < n && t < 1000) begin tick(); t++; end
    check(wr_cnt >= n, "wait_wr", 32'(wr_cnt), 32'(n));
  endtask

  task automatic accept_cmd(input logic [7:0] b);
    bit acc = 1'b0;
    bus.cmd_data = b;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check(acc, "cmd_accept", 32'(acc), 32'd1);
  endtask

  function automatic logic [22:0] out_vec();
    return {bus.wr_ps2, bus.tx_din, bus.cmd_ready, bus.cmd_done_tick, bus.cmd_err,
            bus.strm_valid, bus.strm_data, bus.init_done, bus.init_fail};
  endfunction

  // Reference model: the device answer per attempt decides how many copies of the
  // byte go out and whether the transaction ends in success or exhaustion.
  task automatic run_cmd(input bit is_init, input logic [7:0] b, input int resp[4]);
    bit ok = 1'b0;
    int n_att = 0, base, w0;
    for (int i = 0; i <= MAX_RETRY && !ok; i++) begin
      exp_q.push_back({K_WR, b});
      n_att++;
      if (resp[i] == R_FA || resp[i] == R_FA0) ok = 1'b1;
    end
    if (!is_init) exp_q.push_back({K_DONE, 7'd0, !ok});
    base = done_cnt;
    if (!is_init) accept_cmd(b);
    for (int i = 0; i < n_att; i++) begin
      wait_done(base + i + 1);
      case (resp[i])
        R_FA, R_FE: begin
          repeat ($urandom_range(1, 20)) tick();
          if ($urandom_range(0, 2) == 0) send_rx(garbage());
          send_rx(resp[i] == R_FA ? 8'hFA : 8'hFE);
        end
        R_FA0: begin
          // Land the acknowledge exactly in the cycle the wait timer reads zero.
          while (cyc < done_cyc + ACK_TIMEOUT + 1) tick();
          send_rx(8'hFA);
        end
        default: begin
          if (i < n_att - 1) begin
            w0 = wr_cnt;
            wait_wr(w0 + 1);
            // done tick sampled one edge after done_cyc, timer runs ACK_TIMEOUT+1 edges,
            // then SEND issues the strobe on the following edge.
            check(last_wr_cyc - done_cyc == ACK_TIMEOUT + 3, "retry_gap",
                  32'(last_wr_cyc - done_cyc), 32'(ACK_TIMEOUT + 3));
          end else begin
            repeat (ACK_TIMEOUT + 5) tick();
          end
        end
      endcase
    end
    repeat (4) tick();
    check(exp_q.size() == 0, "sb_drain", 32'(exp_q.size()), 32'd0);
    if (is_init) begin
      check(bus.init_done == ok, "init_done", 32'(bus.init_done), 32'(ok));
      check(bus.init_fail == !ok, "init_fail", 32'(bus.init_fail), 32'(!ok));
    end
  endtask

  task automatic stream_bytes(input logic [7:0] b);
    exp_q.push_back({K_STRM, b});
    send_rx(b);
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check(out_vec() == '0, "reset_outputs", 32'(out_vec()), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
  endtask

  // ---- watchdog ----
  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  // ---- main stimulus ----
  initial begin
    int r[4];
    int w0, t;
    logic [7:0] b;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = 8'h00;

    repeat (3) tick();
    check(out_vec() == '0, "reset_outputs", 32'(out_vec()), 32'd0);
    reset = 1'b1;

    // Init with two resend requests before the acknowledge.
    r = '{R_FE, R_FE, R_FA, R_FA};
    run_cmd(1'b1, 8'hF4, r);
    @(negedge clk);
    check(bus.cmd_ready == 1'b1, "cmd_ready_stream", 32'(bus.cmd_ready), 32'd1);
    tick();

    // User command with a stray byte before the acknowledge, then stream traffic.
    r = '{R_FA, R_FA, R_FA, R_FA};
    exp_q.push_back({K_WR, 8'hF3});
    exp_q.push_back({K_DONE, 8'd0});
    w0 = done_cnt;
    accept_cmd(8'hF3);
    wait_done(w0 + 1);
    repeat (5) tick();
    send_rx(8'h55);
    repeat (3) tick();
    send_rx(8'hFA);
    repeat (3) tick();
    check(exp_q.size() == 0, "sb_drain", 32'(exp_q.size()), 32'd0);
    stream_bytes(8'h08);
    stream_bytes(8'h12);
    stream_bytes(8'h34);
    repeat (2) tick();
    check(exp_q.size() == 0, "strm_drain", 32'(exp_q.size()), 32'd0);

    // Command held while the transmitter is busy must not be taken.
    bus.tx_idle = 1'b0;
    bus.cmd_data = 8'hE8;
    bus.cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check(bus.cmd_ready == 1'b0, "cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.tx_idle = 1'b1;
    r = '{R_FA0, R_FA, R_FA, R_FA};
    run_cmd(1'b0, 8'hE8, r);

    // Randomized commands interleaved with stream bytes.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        t = $urandom_range(0, 9);
        r[i] = (t < 4) ? R_FA : (t < 7) ? R_FE : (t < 9) ? R_TO : R_FA0;
        if (k == 3) r[i] = R_FE;
      end
      run_cmd(1'b0, 8'($urandom), r);
      check(bus.init_done == 1'b1, "init_done_sticky", 32'(bus.init_done), 32'd1);
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        stream_bytes(b);
      end
    end
    repeat (2) tick();
    check(exp_q.size() == 0, "strm_drain", 32'(exp_q.size()), 32'd0);

    // Reset while a command is in flight; init restarts from the first attempt.
    exp_q.push_back({K_WR, 8'hF2});
    w0 = wr_cnt;
    accept_cmd(8'hF2);
    wait_wr(w0 + 1);
    repeat (3) tick();
    pulse_reset();
    reset = 1'b0;
    t = 0;
    while (!bus.tx_idle && t < 100) begin tick(); t++; end
    repeat (2) tick();
    reset = 1'b1;
    r = '{R_FA0, R_FA, R_FA, R_FA};
    run_cmd(1'b1, 8'hF4, r);

    // Device never answers: init exhausts its retries and the block goes terminal.
    pulse_reset();
    r = '{R_TO, R_TO, R_TO, R_TO};
    run_cmd(1'b1, 8'hF4, r);
    @(negedge clk);
    check(bus.cmd_ready == 1'b0, "cmd_ready_fail", 32'(bus.cmd_ready), 32'd0);
    tick();
    send_rx(8'h08);
    repeat (5) tick();
    check(exp_q.size() == 0, "fail_no_strm", 32'(exp_q.size()), 32'd0);
    check(bus.init_fail == 1'b1, "init_fail_sticky", 32'(bus.init_fail), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
